// File: rtl/stream_join_pacer.sv
// ---------------------------------------------------------------------------
// stream_join_pacer
//
// Joins num_ch parallel pixel streams into one beat-aligned output stream.
// A beat fires only when every channel is valid, the single-entry output
// register can take it, and the rate limiter holds a token. Each fired beat
// carries frame-position sideband flags derived from internal x/y counters.
//
// Ports:
//   i_clk          clock
//   i_reset        asynchronous active-low reset
//   i_pace_period  minimum cycles between fires (0 and 1 = unthrottled)
//   i_sync_clear   realign frame position counters to (0,0)
//   i_in_data      packed channel data, channel i at [i*data_width +: data_width]
//   i_in_valid     per-channel valid
//   o_in_ready     per-channel ready (all equal, combinational from i_in_valid)
//   o_out_data     joined beat
//   o_out_valid    output valid
//   i_out_ready    downstream ready
//   o_out_sop      beat is pixel (0,0)
//   o_out_eol      beat is the last pixel of a line
//   o_out_eof      beat is the last pixel of the frame
//   o_frame_count  completed frames, wraps modulo 2^16
// ---------------------------------------------------------------------------

// Per-channel output data register. Loads its slice of the joined beat on
// fire; holds otherwise so data stays stable under back-pressure.
module stream_join_pacer_lane #(
    parameter int data_width = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_load,
    input  logic [data_width-1:0] i_data,
    output logic [data_width-1:0] o_data
);
    logic [data_width-1:0] r_data;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)    r_data <= '0;
        else if (i_load) r_data <= i_data;
    end

    assign o_data = r_data;
endmodule

module stream_join_pacer #(
    parameter int num_ch     = 2,
    parameter int data_width = 16,
    parameter int frame_w    = 80,
    parameter int frame_h    = 160,
    parameter int pace_width = 8
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [pace_width-1:0]        i_pace_period,
    input  logic                         i_sync_clear,
    input  logic [num_ch*data_width-1:0] i_in_data,
    input  logic [num_ch-1:0]            i_in_valid,
    output logic [num_ch-1:0]            o_in_ready,
    output logic [num_ch*data_width-1:0] o_out_data,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic                         o_out_sop,
    output logic                         o_out_eol,
    output logic                         o_out_eof,
    output logic [15:0]                  o_frame_count
);
    localparam int XW = (frame_w > 1) ? $clog2(frame_w) : 1;
    localparam int YW = (frame_h > 1) ? $clog2(frame_h) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(frame_w - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(frame_h - 1);

    typedef struct packed {
        logic sop;
        logic eol;
        logic eof;
    } flags_t;

    // ------------------------------------------------------------------
    // Rate limiter: free-running counter over 0..P-1 banks one token per
    // period. The >= compare makes a shrinking period wrap immediately
    // instead of running up to the counter's full range.
    // ------------------------------------------------------------------
    logic [pace_width-1:0] r_pc;
    logic                  r_tok;
    logic [pace_width-1:0] w_pace_p;
    logic [pace_width-1:0] w_pace_last;
    logic                  w_pc_wrap;

    assign w_pace_p    = (i_pace_period == '0) ? pace_width'(1) : i_pace_period;
    assign w_pace_last = w_pace_p - pace_width'(1);
    assign w_pc_wrap   = (r_pc >= w_pace_last);

    // ------------------------------------------------------------------
    // Join / handshake
    // ------------------------------------------------------------------
    logic r_out_valid;
    logic w_slot_free;
    logic w_fire;

    assign w_slot_free = !r_out_valid || i_out_ready;
    // Qualified by reset so ready reads 0 while the block is held in reset.
    assign w_fire      = i_reset && (&i_in_valid) && w_slot_free && r_tok;
    // Every channel is consumed together; this path is combinational from
    // i_in_valid, so upstream valid must not depend on ready.
    assign o_in_ready  = {num_ch{w_fire}};

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pc  <= '0;
            r_tok <= 1'b1;
        end else begin
            r_pc <= w_pc_wrap ? '0 : r_pc + pace_width'(1);
            // A wrap in the same cycle as a fire re-arms the token, which is
            // what keeps P=1 at one beat per cycle.
            if (w_pc_wrap)   r_tok <= 1'b1;
            else if (w_fire) r_tok <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Frame position
    // ------------------------------------------------------------------
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [15:0]   r_frame_count;
    flags_t        w_flags;

    always_comb begin
        w_flags     = '0;
        w_flags.sop = (r_x == '0) && (r_y == '0);
        w_flags.eol = (r_x == X_LAST);
        w_flags.eof = w_flags.eol && (r_y == Y_LAST);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_x           <= '0;
            r_y           <= '0;
            r_frame_count <= '0;
        end else begin
            // Frame completion counts even if a realign lands on the eof beat.
            if (w_fire && w_flags.eof)
                r_frame_count <= r_frame_count + 16'd1;

            if (i_sync_clear) begin
                r_x <= '0;
                r_y <= '0;
            end else if (w_fire) begin
                if (w_flags.eol) begin
                    r_x <= '0;
                    r_y <= (r_y == Y_LAST) ? '0 : r_y + YW'(1);
                end else begin
                    r_x <= r_x + XW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register: valid + flags here, data in per-channel lanes.
    // ------------------------------------------------------------------
    flags_t r_flags;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_out_valid <= 1'b0;
            r_flags     <= '0;
        end else if (w_fire) begin
            r_out_valid <= 1'b1;
            r_flags     <= w_flags;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    for (genvar g = 0; g < num_ch; g++) begin : g_lane
        stream_join_pacer_lane #(
            .data_width (data_width)
        ) u_lane (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_load  (w_fire),
            .i_data  (i_in_data[g*data_width +: data_width]),
            .o_data  (o_out_data[g*data_width +: data_width])
        );
    end

    assign o_out_valid   = r_out_valid;
    assign o_out_sop     = r_flags.sop;
    assign o_out_eol     = r_flags.eol;
    assign o_out_eof     = r_flags.eof;
    assign o_frame_count = r_frame_count;
endmodule

// File: tb/tb_stream_join_pacer.sv
// Bench for stream_join_pacer on a 4x2 frame with two 16-bit channels.
// Stimulus pushes the expected beat when it sees its inputs consumed; an
// independent monitor pops and compares whenever a beat leaves the DUT.
module tb_stream_join_pacer;
    localparam int NCH = 2;
    localparam int DW  = 16;
    localparam int FW  = 4;
    localparam int FH  = 2;
    localparam int PW  = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [PW-1:0]       pace = 8'd1;
    logic                sync_clear = 1'b0;
    logic [NCH*DW-1:0]   in_data = '0;
    logic [NCH-1:0]      in_valid = '0;
    logic [NCH-1:0]      in_ready;
    logic [NCH*DW-1:0]   o_data;
    logic                o_valid;
    logic                out_ready = 1'b1;
    logic                o_sop, o_eol, o_eof;
    logic [15:0]         fc;

    always #5 clk = ~clk;

    stream_join_pacer #(
        .num_ch(NCH), .data_width(DW), .frame_w(FW), .frame_h(FH), .pace_width(PW)
    ) dut (
        .i_clk(clk), .i_reset(rst_n), .i_pace_period(pace), .i_sync_clear(sync_clear),
        .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .o_out_data(o_data), .o_out_valid(o_valid), .i_out_ready(out_ready),
        .o_out_sop(o_sop), .o_out_eol(o_eol), .o_out_eof(o_eof), .o_frame_count(fc)
    );

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eol;
        logic        eof;
    } beat_t;

    beat_t q[$];
    beat_t mb;
    int asserts = 0;
    int fails   = 0;
    int exp_idx = 0;
    int exp_fc  = 0;
    int pops    = 0;
    int seq     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected flags come from the bench's own beat index within the 4x2 frame.
    task automatic push_exp(input logic [31:0] d);
        beat_t b;
        b.data = d;
        b.sop  = (exp_idx == 0);
        b.eol  = ((exp_idx % FW) == FW - 1);
        b.eof  = (exp_idx == FW * FH - 1);
        q.push_back(b);
        if (b.eof) exp_fc++;
        exp_idx = (exp_idx + 1) % (FW * FH);
    endtask

    function automatic logic [31:0] mk(input int s);
        return {16'(s + 16'h1000), 16'(s)};
    endfunction

    // Present one joined beat; return at posedge+1 after it is consumed.
    // in_valid is left high so back-to-back calls stream with no gap.
    task automatic send_beat(input logic [31:0] d, input bit sc);
        bit done = 0;
        in_data    = d;
        in_valid   = 2'b11;
        sync_clear = sc;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            if (in_ready == 2'b11) begin
                push_exp(d);
                if (sc) exp_idx = 0;
                done = 1;
            end
            @(posedge clk); #1;
        end
        sync_clear = 1'b0;
        if (!done) begin
            asserts++; fails++;
            $display("FAIL send_timeout: got no ready expected ready for data %0h", d);
        end
    endtask

    task automatic idle(input int n);
        in_valid = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: a beat leaves at the next edge when valid && ready at negedge.
    always @(negedge clk) begin
        if (rst_n && o_valid && out_ready) begin
            if (q.size() == 0) begin
                asserts++; fails++;
                $display("FAIL unexpected_beat: got data %0h expected no beat", o_data);
            end else begin
                mb = q.pop_front();
                check("beat_data", o_data, mb.data);
                check("beat_sop", o_sop, mb.sop);
                check("beat_eol", o_eol, mb.eol);
                check("beat_eof", o_eof, mb.eof);
                pops++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0, s1, nf, p0, last_fire, fcb;
        // ---------------- reset state ----------------
        in_valid = 2'b11;
        #12;
        check("rst_in_ready", in_ready, 2'b00);
        check("rst_out_valid", o_valid, 0);
        check("rst_out_data", o_data, 0);
        check("rst_flags", {o_sop, o_eol, o_eof}, 3'b000);
        check("rst_frame_count", fc, 0);
        in_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ---------------- one full frame at full rate ----------------
        for (int i = 0; i < 8; i++) send_beat(mk(seq++), 0);
        idle(3);
        check("frame_count_after_frame", fc, 16'd1);
        check("frame_count_model", fc, 16'(exp_fc));

        // ---------------- ch1 valid on odd cycles only ----------------
        s0 = 0; s1 = 0; nf = 0; p0 = pops;
        for (int c = 0; c < 20; c++) begin
            in_valid = {c[0], 1'b1};
            in_data  = {16'(100 + s1), 16'(s0)};
            @(negedge clk);
            if (in_valid[1] == 1'b0) check("ready_without_ch1", in_ready, 2'b00);
            if (in_ready == 2'b11) begin
                push_exp(in_data);
                nf++; s0++; s1++;
            end
            @(posedge clk); #1;
        end
        idle(3);
        check("ch1_fire_count", nf, 10);
        check("ch1_beats_out", pops - p0, 10);

        // ---------------- pace_period = 3 ----------------
        pace = 8'd3; nf = 0; last_fire = -1;
        in_valid = 2'b11;
        in_data  = mk(seq);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (in_ready == 2'b11) begin
                push_exp(in_data);
                if (last_fire >= 0) check("pace_gap", c - last_fire, 3);
                last_fire = c;
                nf++;
                @(posedge clk); #1;
                seq++;
                in_data = mk(seq);
            end else begin
                @(posedge clk); #1;
            end
        end
        in_valid = '0;
        pace = 8'd1;
        idle(3);
        check("pace_beats_in_30", (nf >= 9 && nf <= 11), 1);

        // ---------------- back-pressure for 5 cycles ----------------
        for (int i = 0; i < 3; i++) send_beat(mk(seq++), 0);
        out_ready = 1'b0;
        in_data   = mk(seq);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_valid", o_valid, 1);
            check("stall_in_ready", in_ready, 2'b00);
            check("stall_data", o_data, q[$].data);
            check("stall_flags", {o_sop, o_eol, o_eof}, {q[$].sop, q[$].eol, q[$].eof});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_beat(mk(seq++), 0);
        idle(3);

        // ---------------- sync_clear coincident with fire at (2,1) ----------------
        for (int i = 0; i < 8 && exp_idx != 6; i++) send_beat(mk(seq++), 0);
        fcb = exp_fc;
        send_beat(mk(seq++), 1);
        send_beat(mk(seq++), 0);
        send_beat(mk(seq++), 0);
        idle(3);
        check("sync_clear_frame_count", fc, 16'(fcb));

        // ---------------- async reset mid-frame at beat 5 ----------------
        for (int i = 0; i < 8 && exp_idx != 5; i++) send_beat(mk(seq++), 0);
        send_beat(mk(seq++), 0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", o_valid, 0);
        check("midrst_in_ready", in_ready, 2'b00);
        check("midrst_frame_count", fc, 0);
        q.delete();
        exp_idx = 0;
        exp_fc  = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) send_beat(mk(seq++), 0);
        idle(3);
        check("post_rst_frame_count", fc, 0);

        idle(3);
        check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
